// File: rtl/ucsbece152a_mod_counter_if.sv
// ucsbece152a_mod_counter_if: control and status bundle for one counter digit.
// master drives the controls and observes the count; slave is the counter.
interface ucsbece152a_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable_i;
  logic             dir_i;
  logic             clear_i;
  logic             load_i;
  logic [WIDTH-1:0] load_value_i;
  logic             sat_i;
  logic [WIDTH-1:0] count_o;
  logic             tc_o;
  logic             carry_o;
  logic             ovf_o;

  modport master (
    output enable_i,
    output dir_i,
    output clear_i,
    output load_i,
    output load_value_i,
    output sat_i,
    input  count_o,
    input  tc_o,
    input  carry_o,
    input  ovf_o
  );

  modport slave (
    input  enable_i,
    input  dir_i,
    input  clear_i,
    input  load_i,
    input  load_value_i,
    input  sat_i,
    output count_o,
    output tc_o,
    output carry_o,
    output ovf_o
  );
endinterface

// File: rtl/ucsbece152a_mod_counter.sv
// ucsbece152a_mod_counter: modulo-N up/down digit with prescaler and carry.
// Define UCSBECE152A_COUNTER_SAT_EN to make sat_i/ovf_o live.
module ucsbece152a_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  ucsbece152a_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

`ifdef UCSBECE152A_COUNTER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  generate
    if (MODULUS < 2 ||
        ((WIDTH < 31) && (MODULUS > (1 << WIDTH))))
    begin : g_bad_modulus
      $error("MODULUS out of range for WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("PRESCALE must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [PW-1:0]    psc_q;
  logic [PW-1:0]    psc_d;
  logic             carry_q;
  logic             carry_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             tick;
  logic             at_top;
  logic             at_bot;
  logic             at_term;
  logic             saturate;
  logic             load_big;
  logic [WIDTH-1:0] load_clamp;
  logic             do_clear;
  logic             do_load;
  logic             do_run;

  assign tick     = psc_q == PSC_LAST;
  assign at_top   = count_q == LAST;
  assign at_bot   = count_q == '0;
  assign at_term  = bus.dir_i ? at_bot : at_top;
  assign saturate = SAT_EN & bus.sat_i;

  // Compare one bit wider so MODULUS == 2**WIDTH never clamps.
  assign load_big   = {1'b0, bus.load_value_i} > {1'b0, LAST};
  assign load_clamp = load_big ? LAST : bus.load_value_i;

  assign do_clear = bus.clear_i;
  assign do_load  = !bus.clear_i && bus.load_i;
  assign do_run   = !bus.clear_i && !bus.load_i && bus.enable_i;

  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (1'b1)
      do_clear: begin
        count_d = '0;
        psc_d   = '0;
        ovf_d   = 1'b0;
      end
      do_load: begin
        count_d = load_clamp;
        psc_d   = '0;
        ovf_d   = 1'b0;
      end
      do_run: begin
        if (!tick) begin
          psc_d = psc_q + 1'b1;
        end else begin
          psc_d = '0;
          if (!at_term) begin
            count_d = bus.dir_i ? count_q - 1'b1
                                : count_q + 1'b1;
          end else if (saturate) begin
            ovf_d = 1'b1;
          end else begin
            count_d = bus.dir_i ? LAST : '0;
            carry_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      psc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count_o = count_q;
  assign bus.carry_o = carry_q;
  assign bus.ovf_o   = SAT_EN ? ovf_q : 1'b0;
  assign bus.tc_o    = at_term;

endmodule

// File: tb/tb_ucsbece152a_mod_counter.sv
// tb_ucsbece152a_mod_counter: scoreboard bench for two digits sharing inputs,
// one with PRESCALE=1 (dut_a) and one with PRESCALE=3 (dut_b).
module tb_ucsbece152a_mod_counter;

  localparam int M  = 10;
  localparam int PB = 3;

`ifdef UCSBECE152A_COUNTER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ucsbece152a_mod_counter_if #(.WIDTH(4)) ifa ();
  ucsbece152a_mod_counter_if #(.WIDTH(4)) ifb ();

  assign ifb.enable_i     = ifa.enable_i;
  assign ifb.dir_i        = ifa.dir_i;
  assign ifb.clear_i      = ifa.clear_i;
  assign ifb.load_i       = ifa.load_i;
  assign ifb.load_value_i = ifa.load_value_i;
  assign ifb.sat_i        = ifa.sat_i;

  ucsbece152a_mod_counter #(
    .WIDTH(4), .MODULUS(M), .PRESCALE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  ucsbece152a_mod_counter #(
    .WIDTH(4), .MODULUS(M), .PRESCALE(PB)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    int cnt;
    int psc;
    bit ovf;
    bit car;
  } mdl_t;

  typedef struct {
    int a_cnt;
    bit a_car;
    bit a_ovf;
    bit a_tc;
    int b_cnt;
    bit b_car;
  } exp_t;

  mdl_t ma;
  mdl_t mb;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  function automatic mdl_t nxt(input mdl_t s, input int p,
                               input bit en, input bit dir,
                               input bit clr, input bit ld,
                               input int lv, input bit sat);
    mdl_t r;
    r = s;
    r.car = 1'b0;
    if (clr) begin
      r.cnt = 0; r.psc = 0; r.ovf = 1'b0;
    end else if (ld) begin
      r.cnt = (lv >= M) ? M - 1 : lv;
      r.psc = 0; r.ovf = 1'b0;
    end else if (en) begin
      if (s.psc < p - 1) begin
        r.psc = s.psc + 1;
      end else begin
        r.psc = 0;
        if ((!dir && s.cnt == M - 1) || (dir && s.cnt == 0)) begin
          if (sat && SAT_EN) begin
            r.ovf = 1'b1;
          end else begin
            r.cnt = dir ? M - 1 : 0;
            r.car = 1'b1;
          end
        end else begin
          r.cnt = dir ? s.cnt - 1 : s.cnt + 1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    ma = '{0, 0, 1'b0, 1'b0};
    mb = '{0, 0, 1'b0, 1'b0};
  endtask

  task automatic cyc(input bit en, input bit dir, input bit clr,
                     input bit ld, input int lv, input bit sat);
    exp_t x;
    ifa.enable_i     = en;
    ifa.dir_i        = dir;
    ifa.clear_i      = clr;
    ifa.load_i       = ld;
    ifa.load_value_i = 4'(lv);
    ifa.sat_i        = sat;
    ma = nxt(ma, 1, en, dir, clr, ld, lv, sat);
    mb = nxt(mb, PB, en, dir, clr, ld, lv, sat);
    x.a_cnt = ma.cnt;
    x.a_car = ma.car;
    x.a_ovf = ma.ovf;
    x.a_tc  = dir ? (ma.cnt == 0) : (ma.cnt == M - 1);
    x.b_cnt = mb.cnt;
    x.b_car = mb.car;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifa.enable_i = 1'b1; ifa.dir_i = 1'b0;
    ifa.clear_i = 1'b0; ifa.load_i = 1'b0;
    ifa.load_value_i = 4'd0; ifa.sat_i = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    checks++;
    if (ifa.count_o !== 4'd0 || ifb.count_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d want 0/0",
               ifa.count_o, ifb.count_o);
    end
    checks++;
    if (ifa.carry_o !== 1'b0 || ifa.ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got carry=%b ovf=%b want 0 0",
               ifa.carry_o, ifa.ovf_o);
    end
    checks++;
    if (ifa.tc_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc_up got %b want 0", ifa.tc_o);
    end
    ifa.dir_i = 1'b1;
    #1;
    checks++;
    if (ifa.tc_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down got %b want 1", ifa.tc_o);
    end
    ifa.dir_i = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (ifa.count_o !== 4'(e.a_cnt) || ifa.carry_o !== e.a_car) begin
        errors++;
        $display("FAIL up_a edge=%0d got cnt=%0d car=%b want cnt=%0d car=%b",
                 i + 1, ifa.count_o, ifa.carry_o, e.a_cnt, e.a_car);
      end
      checks++;
      if (ifa.tc_o !== e.a_tc) begin
        errors++;
        $display("FAIL up_tc edge=%0d got %b want %b", i + 1, ifa.tc_o, e.a_tc);
      end
      checks++;
      if (ifb.count_o !== 4'(e.b_cnt) || ifb.carry_o !== e.b_car) begin
        errors++;
        $display("FAIL up_b edge=%0d got cnt=%0d car=%b want cnt=%0d car=%b",
                 i + 1, ifb.count_o, ifb.carry_o, e.b_cnt, e.b_car);
      end
    end
    checks++;
    if (ifa.count_o !== 4'd2) begin
      errors++;
      $display("FAIL up_final got %0d want 2", ifa.count_o);
    end
  endtask

  task automatic test_count_down();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (ifa.count_o !== 4'd0 || ifb.count_o !== 4'd0) begin
      errors++;
      $display("FAIL down_clear got %0d/%0d want 0/0", ifa.count_o, ifb.count_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (ifa.count_o !== 4'(e.a_cnt) || ifa.carry_o !== e.a_car ||
          ifa.tc_o !== e.a_tc) begin
        errors++;
        $display("FAIL down_a edge=%0d got cnt=%0d car=%b tc=%b want %0d %b %b",
                 i + 1, ifa.count_o, ifa.carry_o, ifa.tc_o,
                 e.a_cnt, e.a_car, e.a_tc);
      end
    end
  endtask

  task automatic test_load_clear();
    int lv[3];
    bit cl[3];
    lv = '{7, 13, 4};
    cl = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, cl[i], 1'b1, lv[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if (ifa.count_o !== 4'(e.a_cnt) || ifb.count_o !== 4'(e.b_cnt) ||
          ifa.carry_o !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d got %0d/%0d car=%b want %0d/%0d car=0",
                 i, ifa.count_o, ifb.count_o, ifa.carry_o, e.a_cnt, e.b_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    bit en[6];
    bit dr[6];
    bit ld[6];
    int lv[6];
    en = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    dr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    lv = '{9, 0, 0, 3, 0, 0};
    for (int i = 0; i < 6; i++) begin
      cyc(en[i], dr[i], 1'b0, ld[i], lv[i], 1'b1);
      e = sb.pop_front();
      checks++;
      if (ifa.count_o !== 4'(e.a_cnt) || ifa.ovf_o !== e.a_ovf ||
          ifa.carry_o !== e.a_car) begin
        errors++;
        $display("FAIL sat_%0d got cnt=%0d ovf=%b car=%b want %0d %b %b",
                 i, ifa.count_o, ifa.ovf_o, ifa.carry_o,
                 e.a_cnt, e.a_ovf, e.a_car);
      end
    end
  endtask

  task automatic test_prescale();
    int step2_edge;
    bit en;
    step2_edge = -1;
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      en = !(i >= 5 && i <= 9);
      cyc(en, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (ifb.count_o !== 4'(e.b_cnt)) begin
        errors++;
        $display("FAIL presc edge=%0d got %0d want %0d",
                 i, ifb.count_o, e.b_cnt);
      end
      if (ifb.count_o == 4'd2 && step2_edge < 0) step2_edge = i;
    end
    checks++;
    if (step2_edge != 11) begin
      errors++;
      $display("FAIL presc_delay got edge %0d want 11", step2_edge);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    e = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      e = sb.pop_front();
    end
    checks++;
    if (ifa.count_o !== 4'd6) begin
      errors++;
      $display("FAIL arst_pre got %0d want 6", ifa.count_o);
    end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ifa.count_o !== 4'd0 || ifb.count_o !== 4'd0 ||
        ifa.carry_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got %0d/%0d car=%b want 0/0 car=0",
               ifa.count_o, ifb.count_o, ifa.carry_o);
    end
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (ifa.count_o !== 4'd1 || ifb.count_o !== 4'(e.b_cnt)) begin
      errors++;
      $display("FAIL arst_after got %0d/%0d want 1/%0d",
               ifa.count_o, ifb.count_o, e.b_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0,
          int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      e = sb.pop_front();
      checks++;
      if (ifa.count_o !== 4'(e.a_cnt) || ifa.carry_o !== e.a_car ||
          ifa.ovf_o !== e.a_ovf || ifa.tc_o !== e.a_tc ||
          ifb.count_o !== 4'(e.b_cnt) || ifb.carry_o !== e.b_car) begin
        errors++;
        $display("FAIL rand_%0d got a=%0d/%b/%b/%b b=%0d/%b want a=%0d/%b/%b/%b b=%0d/%b",
                 i, ifa.count_o, ifa.carry_o, ifa.ovf_o, ifa.tc_o,
                 ifb.count_o, ifb.carry_o, e.a_cnt, e.a_car, e.a_ovf,
                 e.a_tc, e.b_cnt, e.b_car);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clear();
    test_saturate();
    test_prescale();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
